instruction_aligner: RTL and testbench

INSTRUCTION_ALIGNER -- requirements
Module: instruction_aligner

---
 rtl/instruction_aligner_pkg.sv | 29 ++
 rtl/instruction_aligner_if.sv | 24 ++
 rtl/instruction_aligner_length_decoder.sv | 21 ++
 rtl/instruction_aligner.sv | 97 +++++++++
 tb/tb_instruction_aligner.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_aligner_pkg.sv
// Shared widths and instruction-format definitions for the instruction aligner.
// Package name pa_pkg is kept so existing importers continue to compile.
package pa_pkg;

    localparam int unsigned FETCH_WIDTH = 32;
    localparam int unsigned BUF_WIDTH   = 64;
    localparam int unsigned LONG_LEN    = 30;
    localparam int unsigned SHORT_LEN   = 19;
    localparam int unsigned CNT_WIDTH   = 7;

    typedef logic [CNT_WIDTH-1:0] count_t;

    typedef enum logic {
        FMT_SHORT = 1'b0,
        FMT_LONG  = 1'b1
    } format_e;

    function automatic count_t format_length(input format_e fmt);
        return (fmt == FMT_LONG) ? count_t'(LONG_LEN) : count_t'(SHORT_LEN);
    endfunction

    // Keeps the top `length` bits of a fetch-width word, zeroing the rest.
    function automatic logic [FETCH_WIDTH-1:0] length_mask(input format_e fmt);
        logic [FETCH_WIDTH-1:0] ones;
        ones = '1;
        return ones << (FETCH_WIDTH - int'(format_length(fmt)));
    endfunction

endpackage

// File: rtl/instruction_aligner_if.sv
// Fetch-side handshake, pipeline control and aligned-instruction output bundle.
interface instruction_aligner_if;
    import pa_pkg::*;

    logic                   flush_i;
    logic                   stall_i;
    logic [FETCH_WIDTH-1:0] fetchWord_i;
    logic                   fetchValid_i;
    logic                   fetchReady_o;
    logic [FETCH_WIDTH-1:0] Instruction_o;
    logic                   InstructionFormat_o;
    logic                   enable_o;

    modport master (
        output flush_i, stall_i, fetchWord_i, fetchValid_i,
        input  fetchReady_o, Instruction_o, InstructionFormat_o, enable_o
    );

    modport slave (
        input  flush_i, stall_i, fetchWord_i, fetchValid_i,
        output fetchReady_o, Instruction_o, InstructionFormat_o, enable_o
    );

endinterface

// File: rtl/instruction_aligner_length_decoder.sv
// Combinational head-of-buffer decode: format, length, availability and fetch ready.
module instr_length_decoder
    import pa_pkg::*;
(
    input  logic    reset,
    input  logic    head_bit,
    input  count_t  bit_count,
    output format_e format,
    output count_t  length,
    output logic    available,
    output logic    ready
);

    always_comb begin
        format    = format_e'(head_bit);
        length    = format_length(format);
        available = (bit_count != '0) && (bit_count >= length);
        ready     = !reset && (bit_count <= count_t'(FETCH_WIDTH));
    end

endmodule

// File: rtl/instruction_aligner.sv
// Bit-stream aligner extracting 30/19-bit instructions from 32-bit fetch words.
// Define ALIGNER_NOP_FILTER_EN to consume nops (aligned bits [27:21] == 0) silently.
module instruction_aligner
    import pa_pkg::*;
(
    input  logic                 clock_i,
    input  logic                 reset_i,
    instruction_aligner_if.slave bus
);

    logic [BUF_WIDTH-1:0]   bit_buffer;
    logic [BUF_WIDTH-1:0]   remain_buffer;
    logic [BUF_WIDTH-1:0]   buffer_next;
    count_t                 bit_count;
    count_t                 remain_count;
    count_t                 count_next;

    logic [FETCH_WIDTH-1:0] instruction;
    logic [FETCH_WIDTH-1:0] head_instr;
    format_e                format;
    format_e                head_format;
    logic                   enable;

    count_t                 head_length;
    logic                   available;
    logic                   ready;
    logic                   consume;
    logic                   accept;
    logic                   emit;

    instr_length_decoder u_decoder (
        .reset     (reset_i),
        .head_bit  (bit_buffer[BUF_WIDTH-1]),
        .bit_count (bit_count),
        .format    (head_format),
        .length    (head_length),
        .available (available),
        .ready     (ready)
    );

    always_comb begin
        head_instr = bit_buffer[BUF_WIDTH-1 -: FETCH_WIDTH] & length_mask(head_format);
        consume    = !bus.stall_i && !bus.flush_i && available;
        accept     = bus.fetchValid_i && ready;
`ifdef ALIGNER_NOP_FILTER_EN
        emit       = consume && (head_instr[27:21] != '0);
`else
        emit       = consume;
`endif

        remain_buffer = bit_buffer;
        remain_count  = bit_count;
        if (consume) begin
            remain_buffer = bit_buffer << head_length;
            remain_count  = bit_count - head_length;
        end

        // Bits below the valid count are always zero, so the new word can be OR-ed in.
        buffer_next = remain_buffer;
        count_next  = remain_count;
        if (accept) begin
            buffer_next = remain_buffer
                        | ({bus.fetchWord_i, {(BUF_WIDTH-FETCH_WIDTH){1'b0}}} >> remain_count);
            count_next  = remain_count + count_t'(FETCH_WIDTH);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            bit_buffer  <= '0;
            bit_count   <= '0;
            instruction <= '0;
            format      <= FMT_SHORT;
            enable      <= 1'b0;
        end else if (bus.flush_i) begin
            bit_buffer  <= '0;
            bit_count   <= '0;
            enable      <= 1'b0;
        end else begin
            bit_buffer <= buffer_next;
            bit_count  <= count_next;
            if (!bus.stall_i) begin
                enable <= emit;
                if (emit) begin
                    instruction <= head_instr;
                    format      <= head_format;
                end
            end
        end
    end

    assign bus.fetchReady_o        = ready;
    assign bus.Instruction_o       = instruction;
    assign bus.InstructionFormat_o = format;
    assign bus.enable_o            = enable;

endmodule

// File: tb/tb_instruction_aligner.sv
// Self-checking bench for instruction_aligner against a bit-queue reference model.
module tb_instruction_aligner;

    logic clock_i = 1'b0;
    logic reset_i;

    instruction_aligner_if bus ();

    instruction_aligner dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clock_i = ~clock_i;

`ifdef ALIGNER_NOP_FILTER_EN
    localparam bit NOP_FILTER = 1'b1;
`else
    localparam bit NOP_FILTER = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: the buffered stream as a queue of bits, oldest first.
    bit          m_q[$];
    logic [31:0] m_instr;
    logic        m_fmt;
    logic        m_en;
    logic        exp_ready;
    logic        obs_ready;

    task automatic model_clear();
        m_q.delete();
        m_instr = '0;
        m_fmt   = 1'b0;
        m_en    = 1'b0;
    endtask

    task automatic cycle(input logic valid, input logic [31:0] word,
                         input logic stall, input logic flush);
        int          len;
        logic [31:0] ins;
        bit          acc;
        bus.fetchValid_i = valid;
        bus.fetchWord_i  = word;
        bus.stall_i      = stall;
        bus.flush_i      = flush;
        @(negedge clock_i);
        obs_ready = bus.fetchReady_o;
        exp_ready = (reset_i == 1'b0) && (m_q.size() <= 32);
        acc = valid && exp_ready;
        @(posedge clock_i);
        if (flush) begin
            m_q.delete();
            m_en = 1'b0;
        end else begin
            if (!stall) begin
                len = (m_q.size() > 0 && m_q[0]) ? 30 : 19;
                if (m_q.size() > 0 && m_q.size() >= len) begin
                    ins = '0;
                    for (int i = 0; i < len; i++) ins[31-i] = m_q.pop_front();
                    if (NOP_FILTER && ins[27:21] == 7'd0) begin
                        m_en = 1'b0;
                    end else begin
                        m_en    = 1'b1;
                        m_instr = ins;
                        m_fmt   = (len == 30);
                    end
                end else begin
                    m_en = 1'b0;
                end
            end
            if (acc) for (int i = 0; i < 32; i++) m_q.push_back(word[31-i]);
        end
        #1;
    endtask

    task automatic apply_reset();
        reset_i          = 1'b1;
        bus.fetchValid_i = 1'b0;
        bus.fetchWord_i  = '0;
        bus.stall_i      = 1'b0;
        bus.flush_i      = 1'b0;
        model_clear();
        repeat (2) @(posedge clock_i);
        #1 reset_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i          = 1'b1;
        bus.fetchValid_i = 1'b0;
        bus.fetchWord_i  = '0;
        bus.stall_i      = 1'b0;
        bus.flush_i      = 1'b0;
        model_clear();
        #2;
        checks++;
        if (bus.enable_o !== 1'b0) begin errors++; $display("FAIL reset_enable got=%b exp=0", bus.enable_o); end
        checks++;
        if (bus.Instruction_o !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", bus.Instruction_o); end
        checks++;
        if (bus.InstructionFormat_o !== 1'b0) begin errors++; $display("FAIL reset_format got=%b exp=0", bus.InstructionFormat_o); end
        checks++;
        if (int'(dut.bit_count) !== 0) begin errors++; $display("FAIL reset_count got=%0d exp=0", dut.bit_count); end
        checks++;
        if (bus.fetchReady_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.fetchReady_o); end
        @(posedge clock_i);
        #1 reset_i = 1'b0;
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        cycle(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        #3 reset_i = 1'b1;
        model_clear();
        #1;
        checks++;
        if (int'(dut.bit_count) !== 0) begin errors++; $display("FAIL midreset_count got=%0d exp=0", dut.bit_count); end
        checks++;
        if (bus.fetchReady_o !== 1'b0) begin errors++; $display("FAIL midreset_ready got=%b exp=0", bus.fetchReady_o); end
        @(posedge clock_i);
        #1 reset_i = 1'b0;
        cycle(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (bus.enable_o !== 1'b1 || bus.Instruction_o !== 32'h7FFF_E000) begin
            errors++;
            $display("FAIL midreset_fresh got en=%b instr=%h exp en=1 instr=7fffe000", bus.enable_o, bus.Instruction_o);
        end
    endtask

    task automatic test_long_word();
        apply_reset();
        cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        checks++;
        if (obs_ready !== 1'b1) begin errors++; $display("FAIL long_ready got=%b exp=1", obs_ready); end
        checks++;
        if (int'(dut.bit_count) !== 32 || bus.enable_o !== 1'b0) begin
            errors++; $display("FAIL long_accept got cnt=%0d en=%b exp cnt=32 en=0", dut.bit_count, bus.enable_o);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (bus.Instruction_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL long_instr got=%h exp=fffffffc", bus.Instruction_o); end
        checks++;
        if (bus.InstructionFormat_o !== 1'b1 || bus.enable_o !== 1'b1) begin
            errors++; $display("FAIL long_flags got fmt=%b en=%b exp fmt=1 en=1", bus.InstructionFormat_o, bus.enable_o);
        end
        checks++;
        if (int'(dut.bit_count) !== 2) begin errors++; $display("FAIL long_count got=%0d exp=2", dut.bit_count); end
    endtask

    task automatic test_short_word();
        apply_reset();
        cycle(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (bus.Instruction_o !== 32'h7FFF_E000) begin errors++; $display("FAIL short_instr got=%h exp=7fffe000", bus.Instruction_o); end
        checks++;
        if (bus.InstructionFormat_o !== 1'b0 || bus.enable_o !== 1'b1) begin
            errors++; $display("FAIL short_flags got fmt=%b en=%b exp fmt=0 en=1", bus.InstructionFormat_o, bus.enable_o);
        end
        checks++;
        if (int'(dut.bit_count) !== 13) begin errors++; $display("FAIL short_count got=%0d exp=13", dut.bit_count); end
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (bus.enable_o !== 1'b0 || int'(dut.bit_count) !== 13) begin
            errors++; $display("FAIL short_wait got en=%b cnt=%0d exp en=0 cnt=13", bus.enable_o, dut.bit_count);
        end
    endtask

    task automatic test_backpressure();
        int          k = 0;
        bit          saw_drop = 0;
        logic [31:0] word;
        apply_reset();
        for (int i = 0; i < 30; i++) begin
            word = k[0] ? 32'hFFFF_FFFF : 32'h0000_0000;
            cycle(1'b1, word, 1'b0, 1'b0);
            if (exp_ready) k++;
            else saw_drop = 1;
            checks++;
            if (obs_ready !== exp_ready || int'(dut.bit_count) !== m_q.size()
                || bus.enable_o !== m_en || bus.Instruction_o !== m_instr
                || bus.InstructionFormat_o !== m_fmt) begin
                errors++;
                $display("FAIL backpressure[%0d] got rdy=%b cnt=%0d en=%b instr=%h fmt=%b exp rdy=%b cnt=%0d en=%b instr=%h fmt=%b",
                         i, obs_ready, dut.bit_count, bus.enable_o, bus.Instruction_o, bus.InstructionFormat_o,
                         exp_ready, m_q.size(), m_en, m_instr, m_fmt);
            end
        end
        checks++;
        if (!saw_drop) begin errors++; $display("FAIL backpressure_drop got=0 exp=1"); end
    endtask

    task automatic test_stall();
        apply_reset();
        cycle(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0);
        cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b0);
            checks++;
            if (bus.enable_o !== 1'b1 || bus.Instruction_o !== 32'h7FFF_E000
                || bus.InstructionFormat_o !== 1'b0 || int'(dut.bit_count) !== 45) begin
                errors++;
                $display("FAIL stall_hold[%0d] got en=%b instr=%h fmt=%b cnt=%0d exp en=1 instr=7fffe000 fmt=0 cnt=45",
                         i, bus.enable_o, bus.Instruction_o, bus.InstructionFormat_o, dut.bit_count);
            end
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (bus.enable_o !== 1'b1 || bus.Instruction_o !== 32'hFFFF_FFFC
            || bus.InstructionFormat_o !== 1'b1 || int'(dut.bit_count) !== 15) begin
            errors++;
            $display("FAIL stall_resume got en=%b instr=%h fmt=%b cnt=%0d exp en=1 instr=fffffffc fmt=1 cnt=15",
                     bus.enable_o, bus.Instruction_o, bus.InstructionFormat_o, dut.bit_count);
        end
    endtask

    task automatic test_flush();
        int guard = 0;
        apply_reset();
        while (m_q.size() != 40 && guard < 20) begin
            cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
            guard++;
        end
        checks++;
        if (int'(dut.bit_count) !== 40) begin errors++; $display("FAIL flush_setup got=%0d exp=40", dut.bit_count); end
        cycle(1'b1, 32'h1234_5678, 1'b0, 1'b1);
        checks++;
        if (int'(dut.bit_count) !== 0 || bus.enable_o !== 1'b0) begin
            errors++; $display("FAIL flush_full got cnt=%0d en=%b exp cnt=0 en=0", dut.bit_count, bus.enable_o);
        end
        cycle(1'b1, 32'h1234_5678, 1'b1, 1'b1);
        checks++;
        if (obs_ready !== 1'b1 || int'(dut.bit_count) !== 0) begin
            errors++; $display("FAIL flush_drop got rdy=%b cnt=%0d exp rdy=1 cnt=0", obs_ready, dut.bit_count);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
            checks++;
            if (bus.enable_o !== 1'b0 || int'(dut.bit_count) !== 0) begin
                errors++; $display("FAIL flush_idle[%0d] got en=%b cnt=%0d exp en=0 cnt=0", i, bus.enable_o, dut.bit_count);
            end
        end
        cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (bus.enable_o !== 1'b1 || bus.Instruction_o !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL flush_restart got en=%b instr=%h exp en=1 instr=fffffffc", bus.enable_o, bus.Instruction_o);
        end
    endtask

    task automatic test_nop();
        logic        exp_en;
        logic [31:0] exp_instr;
        exp_en    = NOP_FILTER ? 1'b0 : 1'b1;
        exp_instr = NOP_FILTER ? 32'h0 : 32'h701F_E000;
        apply_reset();
        cycle(1'b1, 32'h701F_FFFF, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (bus.enable_o !== exp_en || bus.Instruction_o !== exp_instr) begin
            errors++; $display("FAIL nop got en=%b instr=%h exp en=%b instr=%h", bus.enable_o, bus.Instruction_o, exp_en, exp_instr);
        end
        checks++;
        if (int'(dut.bit_count) !== 13) begin errors++; $display("FAIL nop_count got=%0d exp=13", dut.bit_count); end
    endtask

    task automatic test_random();
        logic        valid, stall, flush;
        logic [31:0] word;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            valid = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 39) == 0);
            word  = $urandom();
            cycle(valid, word, stall, flush);
            checks++;
            if (obs_ready !== exp_ready || int'(dut.bit_count) !== m_q.size()
                || bus.enable_o !== m_en || bus.Instruction_o !== m_instr
                || bus.InstructionFormat_o !== m_fmt) begin
                errors++;
                $display("FAIL random[%0d] got rdy=%b cnt=%0d en=%b instr=%h fmt=%b exp rdy=%b cnt=%0d en=%b instr=%h fmt=%b",
                         i, obs_ready, dut.bit_count, bus.enable_o, bus.Instruction_o, bus.InstructionFormat_o,
                         exp_ready, m_q.size(), m_en, m_instr, m_fmt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_midstream();
        test_long_word();
        test_short_word();
        test_backpressure();
        test_stall();
        test_flush();
        test_nop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
